shiftreg_burst: RTL

Parametrised universal shift register, successor to the fixed 16-bit shifter.
- Adds parametrised width, serial in/out, and arithmetic right shift.
- Adds a burst engine that shifts N positions over N cycles under a start/busy/done handshake.
- Sits in the datapath as a parallel-load / serial-shift staging register for serialisers and multi-cycle shift operations.

---
 rtl/shiftreg_burst_if.sv | 32 +++
 rtl/shiftreg_burst.sv | 115 +++++++++++
 2 files changed

// File: rtl/shiftreg_burst_if.sv
// Bus bundle for shiftreg_burst: parallel load, shift controls, burst handshake and outputs.
interface shiftreg_burst_if #(
    parameter int WIDTH = 16
) ();
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] parallel_in;
    logic             load_enable;
    logic             shift_enable;
    logic             left_right;
    logic             arith;
    logic             serial_in;
    logic             rotate;
    logic             burst_start;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] parallel_out;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output parallel_in, load_enable, shift_enable, left_right, arith,
               serial_in, rotate, burst_start, burst_len,
        input  parallel_out, serial_out, busy, done
    );

    modport slave (
        input  parallel_in, load_enable, shift_enable, left_right, arith,
               serial_in, rotate, burst_start, burst_len,
        output parallel_out, serial_out, busy, done
    );
endinterface

// File: rtl/shiftreg_burst.sv
// Universal shift register with a multi-cycle burst engine (start/busy/done).
// Optional rotate support is enabled by defining SHIFTREG_ROTATE_EN.
module shiftreg_burst #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             a_rst_n,
    shiftreg_burst_if.slave  bus
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic             sout_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] rem_q;
    logic             lr_q;
    logic             arith_q;
    logic             rot_q;
    logic             rot_live;

    // Returns {out_bit, next_register} for one shift position.
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic             lr,
        input logic             ar,
        input logic             rot,
        input logic             sin
    );
        logic ob;
        logic fill;
        ob   = lr ? d[WIDTH-1] : d[0];
        fill = (!lr && ar) ? d[WIDTH-1] : sin;
        if (rot) fill = ob;
        return lr ? {ob, d[WIDTH-2:0], fill} : {ob, fill, d[WIDTH-1:1]};
    endfunction

`ifdef SHIFTREG_ROTATE_EN
    assign rot_live = bus.rotate;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n)
            rot_q <= 1'b0;
        else if (!bus.load_enable && state_q == IDLE && bus.burst_start)
            rot_q <= bus.rotate;
    end
`else
    // Rotate tied off so the fill mux folds away to the plain logical/arith paths.
    logic unused_rotate;
    assign unused_rotate = bus.rotate;
    assign rot_live      = 1'b0;
    assign rot_q         = 1'b0;
`endif

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q <= IDLE;
            data_q  <= RESET_VAL;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            lr_q    <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load_enable) begin
                // A load aborts any burst without a done pulse.
                data_q  <= bus.parallel_in;
                state_q <= IDLE;
                busy_q  <= 1'b0;
                rem_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.burst_start) begin
                            lr_q    <= bus.left_right;
                            arith_q <= bus.arith;
                            if (bus.burst_len == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                rem_q   <= bus.burst_len;
                                state_q <= BURST;
                                busy_q  <= 1'b1;
                            end
                        end else if (bus.shift_enable) begin
                            {sout_q, data_q} <= shift_step(data_q, bus.left_right, bus.arith,
                                                           rot_live, bus.serial_in);
                        end
                    end
                    BURST: begin
                        {sout_q, data_q} <= shift_step(data_q, lr_q, arith_q, rot_q, bus.serial_in);
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.parallel_out = data_q;
    assign bus.serial_out   = sout_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule
